// File: rtl/random_arbiter.sv
// random_arbiter: round-robin arbiter handing out bounded random values from a shared LFSR word.
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   rand_in_i   48-bit free-running LFSR word; only [VAL_W-1:0] is used
//   req_i       level requests, one bit per requester
//   limit_i     inclusive upper bound per requester, VAL_W bits each
//   ack_o       registered one-hot delivery pulse
//   rand_out_o  delivered value, held until the next ack
//   busy_o      high whenever a transaction or cool-down is in progress
module random_arbiter #(
  parameter int N_REQ     = 4,
  parameter int VAL_W     = 8,
  parameter int GAP       = 8,
  parameter int MAX_RETRY = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [47:0]            rand_in_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*VAL_W-1:0] limit_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [VAL_W-1:0]       rand_out_o,
  output logic                   busy_o
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = GAP > 1 ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, COOL} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, win_q, win_d, win_idx;
  logic [VAL_W-1:0]   lim_q, lim_d, mask_q, mask_d, lim_sel, mask_n, cand, rand_q, rand_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               found, ok, last;

  // first set request at or above ptr, wrapping around
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % N_REQ]) begin
        found   = 1'b1;
        win_idx = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // smearing the limit downward yields the smallest 2^k-1 covering it
  always_comb begin
    lim_sel = limit_i[int'(win_idx)*VAL_W +: VAL_W];
    mask_n  = lim_sel;
    for (int i = 0; i < VAL_W; i++) mask_n = mask_n | (mask_n >> 1);
  end

  assign cand = rand_in_i[VAL_W-1:0] & mask_q;
  assign ok   = cand <= lim_q;
  assign last = retry_q == RW'(MAX_RETRY);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rand_d  = rand_q;
    case (state_q)
      IDLE: if (found) begin
        win_d   = win_idx;
        lim_d   = lim_sel;
        mask_d  = mask_n;
        retry_d = '0;
        state_d = SAMPLE;
      end
      SAMPLE: if (ok || last) begin
        ack_d   = N_REQ'(1) << win_q;
        rand_d  = ok ? cand : lim_q;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        cnt_d   = CW'(GAP - 1);
        state_d = COOL;
      end else begin
        retry_d = retry_q + 1'b1;
      end
      COOL: begin
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? IDLE : COOL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rand_q  <= rand_d;
    end
  end

  assign ack_o      = ack_q;
  assign rand_out_o = rand_q;
  assign busy_o     = state_q != IDLE;
endmodule

// File: tb/tb_random_arbiter.sv
// tb_random_arbiter: random and directed checks of random_arbiter against a transaction-level model.
module tb_random_arbiter;
  localparam int N = 4, W = 8, G = 8, MR = 7;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] limit = '0;
  logic [47:0] rand_in = '0;
  logic [N-1:0] ack;
  logic [W-1:0] rand_out;
  logic busy;
  int errors = 0, checks = 0, bsy = 0;
  int ph, win, lim, msk, rty, left, ptr, e_ack, e_val;
  int n;
  logic [N-1:0] a;
  logic [N*W-1:0] lim_all_ff = '1;

  always #5 clk = ~clk;

  random_arbiter #(.N_REQ(N), .VAL_W(W), .GAP(G), .MAX_RETRY(MR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rand_in_i(rand_in), .req_i(req), .limit_i(limit),
    .ack_o(ack), .rand_out_o(rand_out), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; ptr = 0; rty = 0; left = 0; e_ack = 0; e_val = 0; win = 0; lim = 0; msk = 0;
  endtask

  // phase 0 idle, 1 sampling, 2 cooling down for GAP cycles after the ack edge
  task automatic model_edge();
    int c;
    if (ph == 0) begin
      e_ack = 0;
      if (req != 0) begin
        for (int o = N - 1; o >= 0; o--) if (req[(ptr + o) % N]) win = (ptr + o) % N;
        lim = int'(limit[win*W +: W]);
        msk = 0;
        while (msk < lim) msk = msk * 2 + 1;
        rty = 0;
        ph = 1;
      end
    end else if (ph == 1) begin
      c = int'(rand_in[W-1:0]) & msk;
      if (c <= lim || rty == MR) begin
        e_ack = 1 << win;
        e_val = (c <= lim) ? c : lim;
        ptr = (win + 1) % N;
        left = G;
        ph = 2;
      end else rty++;
    end else begin
      e_ack = 0;
      left--;
      if (left == 0) ph = 0;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic [47:0] x);
    @(negedge clk);
    req = r; limit = l; rand_in = x;
    @(posedge clk);
    model_edge();
    #1;
    if (busy) bsy++;
    chk("ack", 64'(ack), 64'(e_ack));
    chk("rand_out", 64'(rand_out), 64'(e_val));
    chk("busy", 64'(busy), 64'(ph != 0));
  endtask

  task automatic idle(input int k);
    repeat (k) cyc('0, limit, rand_in);
  endtask

  task automatic run_until_ack(input logic [N-1:0] r, input logic [N*W-1:0] l, input logic [47:0] x,
                               output int cnt, output logic [N-1:0] got);
    cnt = 0; got = '0;
    repeat (40) if (got == 0) begin
      cyc(r, l, x);
      cnt++;
      if (ack != 0) got = ack;
    end
    chk("ack_seen", 64'(got != 0), 64'd1);
  endtask

  function automatic logic [47:0] rnd48();
    logic [47:0] x;
    x[47:16] = $urandom();
    x[15:0] = 16'($urandom());
    return x;
  endfunction

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_val", 64'(rand_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #20 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_until_ack('1, lim_all_ff, rnd48(), n, a);
      chk("rr_order", 64'(a), 64'(1 << (k % N)));
      chk("rr_spacing", 64'(n), 64'(k == 0 ? 2 : G + 2));
    end
    idle(G + 2);
    bsy = 0;
    run_until_ack(4'b0001, lim_all_ff, 48'h5A, n, a);
    chk("lat_ack", 64'(a), 64'b0001);
    chk("lat_edges", 64'(n), 64'd2);
    chk("lat_val", 64'(rand_out), 64'h5A);
    idle(G + 2);
    chk("busy_len", 64'(bsy), 64'(G + 1));
    cyc(4'b0100, {8'hFF, 8'd5, 8'hFF, 8'hFF}, 48'h0);
    cyc(4'b0000, lim_all_ff, 48'h7);
    cyc(4'b0000, lim_all_ff, 48'h6);
    cyc(4'b0000, lim_all_ff, 48'h3);
    chk("retry_ack", 64'(ack), 64'b0100);
    chk("retry_val", 64'(rand_out), 64'd3);
    idle(G + 2);
    run_until_ack(4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'd0}, 48'hFF, n, a);
    chk("lim0_edges", 64'(n), 64'd2);
    chk("lim0_val", 64'(rand_out), 64'd0);
    idle(G + 2);
    run_until_ack(4'b0010, {8'hFF, 8'hFF, 8'd5, 8'hFF}, 48'hFF, n, a);
    chk("clip_ack", 64'(a), 64'b0010);
    chk("clip_edges", 64'(n), 64'(MR + 2));
    chk("clip_val", 64'(rand_out), 64'd5);
    idle(G + 2);
    cyc(4'b0100, {8'hFF, 8'd5, 8'hFF, 8'hFF}, 48'h7);
    cyc(4'b0100, lim_all_ff, 48'h7);
    chk("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 64'(ack), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_val", 64'(rand_out), 64'd0);
    model_reset();
    req = '1;
    @(posedge clk);
    #1;
    chk("held_busy", 64'(busy), 64'd0);
    #2 rst_n = 1'b1;
    run_until_ack('1, lim_all_ff, 48'h12, n, a);
    chk("post_rst_ack", 64'(a), 64'b0001);
    for (int k = 0; k < 600; k++) begin
      logic [N*W-1:0] l;
      for (int i = 0; i < N; i++) begin
        int s;
        s = $urandom_range(0, 3);
        l[i*W +: W] = s == 0 ? 8'd0 : s == 1 ? 8'hFF : 8'($urandom_range(0, 255));
      end
      cyc(4'($urandom_range(0, 15) & $urandom_range(0, 15)), l, rnd48());
      chk("onehot", 64'($countones(ack) <= 1), 64'd1);
      if ($urandom_range(0, 63) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_rst_busy", 64'(busy), 64'd0);
        chk("rnd_rst_ack", 64'(ack), 64'd0);
        model_reset();
        rst_n = 1'b1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
